// File: rtl/vault_access_ctrl.sv
// Time-locked bank vault access controller: IDLE -> DELAY -> WINDOW -> OPEN, with ALARM on any violation.
// Optional `VAULT_ALARM_COUNT_EN adds a saturating count of ALARM entries on port alarm_count.
module vault_access_ctrl #(
  parameter int unsigned DELAY_CYC    = 4,
  parameter int unsigned WINDOW_CYC   = 8,
  parameter int unsigned OPEN_MAX_CYC = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             req,
  input  logic             cofre,
  input  logic             relogio,
  input  logic             gerente,
  input  logic             ack,
  output logic             unlock,
  output logic             alarme,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] remaining
`ifdef VAULT_ALARM_COUNT_EN
  ,
  output logic [CNT_W-1:0] alarm_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DELAY  = 3'd1,
    S_WINDOW = 3'd2,
    S_OPEN   = 3'd3,
    S_ALARM  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ok;

  assign w_ok  = relogio & ~gerente;
  assign state = r_state;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (cofre) begin
          w_next = S_ALARM;
        end else if (req && w_ok) begin
          w_next     = S_DELAY;
          w_cnt_next = CNT_W'(DELAY_CYC - 1);
        end
      end
      S_DELAY: begin
        if (cofre) begin
          w_next = S_ALARM;
        end else if (!w_ok) begin
          w_next = S_IDLE;
        end else if (r_cnt == '0) begin
          w_next     = S_WINDOW;
          w_cnt_next = CNT_W'(WINDOW_CYC - 1);
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_WINDOW: begin
        if (cofre && !w_ok) begin
          w_next = S_ALARM;
        end else if (cofre) begin
          w_next     = S_OPEN;
          w_cnt_next = CNT_W'(OPEN_MAX_CYC - 1);
        end else if (!w_ok || r_cnt == '0) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_OPEN: begin
        if (!cofre) begin
          w_next = S_IDLE;
        end else if (!w_ok || r_cnt == '0) begin
          w_next = S_ALARM;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_ALARM: begin
        // Acknowledge only clears the alarm once the door is shut again.
        if (ack && !cofre) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_ALARM;
    endcase
  end

  // Outputs are registered from the next-state decode so they change on the same edge as the state.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      unlock    <= 1'b0;
      alarme    <= 1'b0;
      remaining <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      unlock    <= (w_next == S_WINDOW) || (w_next == S_OPEN);
      alarme    <= (w_next == S_ALARM);
      remaining <= ((w_next == S_DELAY) || (w_next == S_WINDOW) || (w_next == S_OPEN))
                   ? w_cnt_next : '0;
    end
  end

`ifdef VAULT_ALARM_COUNT_EN
  logic [CNT_W-1:0] r_alarm_cnt;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_alarm_cnt <= '0;
    end else if ((w_next == S_ALARM) && (r_state != S_ALARM) && (r_alarm_cnt != '1)) begin
      r_alarm_cnt <= r_alarm_cnt + 1'b1;
    end
  end

  assign alarm_count = r_alarm_cnt;
`endif

endmodule

// File: tb/tb_vault_access_ctrl.sv
// Self-checking bench for vault_access_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_vault_access_ctrl;

  localparam int DLY = 4;
  localparam int WIN = 8;
  localparam int OMX = 16;
  localparam int CW  = 8;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0, cofre = 1'b0, relogio = 1'b0, gerente = 1'b0, ack = 1'b0;
  logic          unlock, alarme;
  logic [2:0]    state;
  logic [CW-1:0] remaining;
`ifdef VAULT_ALARM_COUNT_EN
  logic [CW-1:0] alarm_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: state as plain numbers 0..4, counter and alarm-entry tally.
  int m_state = 0;
  int m_cnt   = 0;
  int m_acnt  = 0;

  always #5 clk_2 = ~clk_2;

  vault_access_ctrl #(
    .DELAY_CYC   (DLY),
    .WINDOW_CYC  (WIN),
    .OPEN_MAX_CYC(OMX),
    .CNT_W       (CW)
  ) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .req      (req),
    .cofre    (cofre),
    .relogio  (relogio),
    .gerente  (gerente),
    .ack      (ack),
    .unlock   (unlock),
    .alarme   (alarme),
    .state    (state),
    .remaining(remaining)
`ifdef VAULT_ALARM_COUNT_EN
    ,
    .alarm_count(alarm_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state", {29'd0, state}, m_state);
    chk("unlock", {31'd0, unlock}, (m_state == 2 || m_state == 3) ? 1 : 0);
    chk("alarme", {31'd0, alarme}, (m_state == 4) ? 1 : 0);
    chk("remaining", {24'd0, remaining}, (m_state >= 1 && m_state <= 3) ? m_cnt : 0);
`ifdef VAULT_ALARM_COUNT_EN
    chk("alarm_count", {24'd0, alarm_count}, m_acnt);
`endif
  endtask

  task automatic model_step();
    bit ok;
    int prev;
    ok   = relogio && !gerente;
    prev = m_state;
    case (m_state)
      0: if (cofre) m_state = 4;
         else if (req && ok) begin m_state = 1; m_cnt = DLY - 1; end
      1: if (cofre) m_state = 4;
         else if (!ok) m_state = 0;
         else if (m_cnt == 0) begin m_state = 2; m_cnt = WIN - 1; end
         else m_cnt--;
      2: if (cofre && !ok) m_state = 4;
         else if (cofre) begin m_state = 3; m_cnt = OMX - 1; end
         else if (!ok || m_cnt == 0) m_state = 0;
         else m_cnt--;
      3: if (!cofre) m_state = 0;
         else if (!ok || m_cnt == 0) m_state = 4;
         else m_cnt--;
      default: if (ack && !cofre) m_state = 0;
    endcase
    if (m_state == 4 && prev != 4 && m_acnt < 255) m_acnt++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_2);
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Reset pulsed between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_state = 0; m_cnt = 0; m_acnt = 0;
    compare_all();
    #1;
    reset = 1'b0;
  endtask

  task automatic set_in(input logic r, input logic c, input logic rl, input logic g, input logic a);
    req = r; cofre = c; relogio = rl; gerente = g; ack = a;
  endtask

  initial begin
    @(posedge clk_2);
    #1;
    do_reset();

    // Happy path
    set_in(1, 0, 1, 0, 0);
    cycle();
    chk("hp_delay_state", {29'd0, state}, 1);
    chk("hp_delay_rem3", {24'd0, remaining}, 3);
    req = 0;
    cycles(3);
    chk("hp_delay_rem0", {24'd0, remaining}, 0);
    cycle();
    chk("hp_window_state", {29'd0, state}, 2);
    chk("hp_window_unlock", {31'd0, unlock}, 1);
    chk("hp_window_rem7", {24'd0, remaining}, 7);
    cycle();
    cofre = 1;
    cycle();
    chk("hp_open_state", {29'd0, state}, 3);
    chk("hp_open_rem15", {24'd0, remaining}, 15);
    cycles(3);
    cofre = 0;
    cycle();
    chk("hp_close_state", {29'd0, state}, 0);
    chk("hp_close_unlock", {31'd0, unlock}, 0);

    // Window expiry
    req = 1;
    cycle();
    req = 0;
    cycles(3 + 8);
    chk("wx_last_state", {29'd0, state}, 2);
    chk("wx_last_rem0", {24'd0, remaining}, 0);
    cycle();
    chk("wx_idle_state", {29'd0, state}, 0);
    chk("wx_idle_unlock", {31'd0, unlock}, 0);

    // Forced entry
    set_in(0, 1, 0, 0, 0);
    cycle();
    chk("fe_alarm", {31'd0, alarme}, 1);
    ack = 1;
    cycle();
    chk("fe_ack_door_open", {31'd0, alarme}, 1);
    cofre = 0;
    cycle();
    chk("fe_cleared_state", {29'd0, state}, 0);
    chk("fe_cleared_alarme", {31'd0, alarme}, 0);
    ack = 0;

    // Door held too long: alarm on the 16th edge after OPEN entry
    set_in(1, 0, 1, 0, 0);
    cycle();
    req = 0;
    cycles(4);
    cofre = 1;
    cycle();
    cycles(15);
    chk("hold_last_open", {29'd0, state}, 3);
    cycle();
    chk("hold_alarm_state", {29'd0, state}, 4);
    chk("hold_unlock_low", {31'd0, unlock}, 0);
    set_in(0, 0, 1, 0, 1);
    cycle();
    ack = 0;

    // Interlock during DELAY
    req = 1;
    cycle();
    req = 0;
    cycle();
    chk("il_rem2", {24'd0, remaining}, 2);
    gerente = 1;
    cycle();
    chk("il_idle", {29'd0, state}, 0);
    chk("il_no_unlock", {31'd0, unlock}, 0);
    gerente = 0;

    // Reset in OPEN
    req = 1;
    cycle();
    req = 0;
    cycles(4);
    cofre = 1;
    cycle();
    chk("rst_in_open", {29'd0, state}, 3);
    do_reset();
    chk("rst_unlock0", {31'd0, unlock}, 0);
    chk("rst_state0", {29'd0, state}, 0);
    cofre = 0;
    cycle();

`ifdef VAULT_ALARM_COUNT_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 0, 0, 0);
      cycle();
      cofre = 0; ack = 1;
      cycle();
      ack = 0;
    end
    chk("acnt_three", {24'd0, alarm_count}, 3);
    cofre = 1;
    cycles(20);
    chk("acnt_stay", {24'd0, alarm_count}, 4);
    set_in(0, 0, 1, 0, 1);
    cycle();
    ack = 0;
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req     = ($urandom_range(0, 99) < 50);
      relogio = ($urandom_range(0, 99) < 90);
      gerente = ($urandom_range(0, 99) < 8);
      ack     = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 15) cofre = ~cofre;
      if ($urandom_range(0, 249) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vault_access_ctrl.md
Name: vault_access_ctrl

Overview:
Sequential access controller for the bank vault. It replaces the purely combinational vault alarm with a time-locked open sequence. Inputs are the open request, the door sensor, the business-hours clock and the manager's interlock switch. It drives the bolt release, the alarm siren and a status/countdown readout for the board's LEDs and 7-segment display.

Parameters:
DELAY_CYC, 4, time-lock cycles between an accepted request and bolt release (>=1)
WINDOW_CYC, 8, cycles the bolt stays released waiting for the door to open (>=1)
OPEN_MAX_CYC, 16, maximum cycles the door may remain open before alarm (>=1)
CNT_W, 8, width of the countdown and counter outputs; must hold max(parameter)-1

Ports:
clk_2  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  open request, level-sampled each edge
cofre  in  1  door sensor: 0 closed, 1 open
relogio  in  1  business hours: 1 inside hours
gerente  in  1  manager interlock: 1 armed (opening forbidden)
ack  in  1  alarm acknowledge
unlock  out  1  bolt release
alarme  out  1  siren: 1 sounding
state  out  3  encoded FSM state
remaining  out  CNT_W  current countdown value

Behaviour:
- ok = relogio & ~gerente, evaluated combinationally each cycle.
- All outputs are Moore and registered from the state and counter. Any input change is visible one edge later.
- State encoding: IDLE=0, DELAY=1, WINDOW=2, OPEN=3, ALARM=4. Codes 5-7 are illegal and go to ALARM on the next edge.
- Reset (async, any cycle, mid-operation included):
  - state=IDLE, cnt=0.
  - unlock=0, alarme=0, remaining=0.
- Transitions are listed per state in priority order.
- IDLE:
  - cofre -> ALARM.
  - else req & ok -> DELAY, cnt=DELAY_CYC-1.
- DELAY:
  - cofre -> ALARM.
  - else ~ok -> IDLE.
  - else cnt==0 -> WINDOW, cnt=WINDOW_CYC-1.
  - else cnt--.
- WINDOW:
  - cofre & ~ok -> ALARM.
  - cofre & ok -> OPEN, cnt=OPEN_MAX_CYC-1.
  - else ~ok -> IDLE.
  - else cnt==0 -> IDLE.
  - else cnt--.
- OPEN:
  - ~cofre -> IDLE.
  - else ~ok -> ALARM.
  - else cnt==0 -> ALARM.
  - else cnt--.
- ALARM:
  - ack & ~cofre -> IDLE.
  - else stay; ack with door open is ignored.
- Output decode:
  - unlock=1 only in WINDOW and OPEN.
  - alarme=1 only in ALARM.
  - remaining=cnt in DELAY/WINDOW/OPEN, else 0.
- req is ignored outside IDLE. Holding req does not retrigger until the FSM returns to IDLE.
- Counter never wraps: decrement happens only when cnt!=0.

Optional Feature:
VAULT_ALARM_COUNT_EN
- Defined: adds output alarm_count [CNT_W-1:0], cleared by reset. It increments by 1 on every transition into ALARM (not while remaining there) and saturates at all-ones.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Happy path: reset; relogio=1, gerente=0; req=1 sampled at edge k -> DELAY at k with remaining 3,2,1,0 over edges k..k+3. WINDOW at k+4 with unlock=1. cofre=1 at k+6 -> OPEN. cofre=0 at k+10 -> IDLE, unlock=0, alarme never 1.
2. Window expiry: happy path without opening the door -> 8 cycles in WINDOW (remaining 7..0), then IDLE, unlock=0, alarme=0.
3. Forced entry: relogio=0, cofre=1 in IDLE -> alarme=1 next edge. ack=1 with cofre=1 -> alarme stays 1. cofre=0 & ack=1 -> IDLE, alarme=0.
4. Door held too long: enter OPEN and keep cofre=1 -> ALARM on the 16th edge after OPEN entry; unlock falls to 0 on that same edge.
5. Interlock and reset: gerente=1 during DELAY (remaining=2) -> IDLE next edge, unlock never asserted. Reset pulsed in OPEN, between edges -> unlock, alarme, state, remaining all 0 immediately.
6. With VAULT_ALARM_COUNT_EN: three separate forced entries -> alarm_count=3. Staying in ALARM for 20 cycles does not increment it.
